// File: rtl/float_pack.sv
// Shared float format (Nm/Ne), integer width, exponent bias and the
// float_conv FSM state enum.
package float_pack;

  localparam int Nm    = 23;
  localparam int Ne    = 8;
  localparam int Nf    = 1 + Ne + Nm;
  localparam int INT_W = 32;
  localparam int BIAS  = 2 ** (Ne - 1) - 1;

  typedef struct packed {
    logic          sign;
    logic [Ne-1:0] exponent;
    logic [Nm-1:0] mantissa;
  } float_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PACK,
    DONE
  } conv_state_t;

endpackage

// File: rtl/float_conv_lzc.sv
// Combinational leading-zero count of a 32-bit word; returns 32 for zero.
module float_conv_lzc
  import float_pack::*;
(
  input  logic [INT_W-1:0] value,
  output logic [5:0]       count
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    count = 6'(INT_W);
    for (int i = 0; i < INT_W; i++) begin
      if (value[i]) count = 6'(INT_W - 1 - i);
    end
  end

endmodule

// File: rtl/float_conv.sv
// Multi-cycle int<->float converter using a 1-bit-per-cycle shift loop.
// Define FLOAT_CONV_ROUND_EN for round-to-nearest (ties away) on int-to-float.
module float_conv
  import float_pack::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [INT_W-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [INT_W-1:0] result
);

  conv_state_t      state, state_nxt;
  logic             op_r, sign_r, zero_r, sat_r, left_r;
  logic [5:0]       k_r, cnt_r;
  logic [INT_W-1:0] work_r;

  logic [INT_W-1:0] mag;
  logic [5:0]       lz;
  float_t           f_in;
  int               e_in;

  logic             cap_sign, cap_zero, cap_sat, cap_left;
  logic [5:0]       cap_k;
  logic [INT_W-1:0] cap_work;

  logic             round_bit;
  logic [Nm:0]      mant_rnd;
  int               exp_val;
  float_t           flt;
  logic [INT_W-1:0] pack_val;

  assign mag  = a[INT_W-1] ? (~a + 1'b1) : a;
  assign f_in = float_t'(a[Nf-1:0]);

  float_conv_lzc u_lzc (
    .value (mag),
    .count (lz)
  );

  // Classify the operand and work out the shift distance before capture.
  always_comb begin
    cap_sign = 1'b0;
    cap_zero = 1'b0;
    cap_sat  = 1'b0;
    cap_left = 1'b1;
    cap_k    = '0;
    cap_work = '0;
    e_in     = int'(f_in.exponent) - BIAS;
    if (!op) begin
      cap_sign = a[INT_W-1];
      cap_work = mag;
      if (mag == '0) cap_zero = 1'b1;
      else           cap_k    = lz;
    end else begin
      cap_sign = f_in.sign;
      cap_work = INT_W'({1'b1, f_in.mantissa});
      if (f_in.exponent == '1 || e_in >= INT_W - 1) begin
        cap_sat = 1'b1;
      end else if (f_in.exponent == '0 || e_in < 0) begin
        cap_zero = 1'b1;
      end else if (e_in < Nm) begin
        cap_left = 1'b0;
        cap_k    = 6'(Nm - e_in);
      end else begin
        cap_k    = 6'(e_in - Nm);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cap_k == '0) ? PACK : SHIFT;
      SHIFT:   if (cnt_r == 6'd1) state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Final packing of the normalised/shifted working register.
  always_comb begin
    pack_val = '0;
    flt      = '0;
`ifdef FLOAT_CONV_ROUND_EN
    round_bit = work_r[INT_W-2-Nm];
`else
    round_bit = 1'b0;
`endif
    mant_rnd = {1'b0, work_r[INT_W-2 -: Nm]} + {{Nm{1'b0}}, round_bit};
    exp_val  = BIAS + (INT_W - 1) - int'(k_r) + int'(mant_rnd[Nm]);
    if (!op_r) begin
      flt.sign = sign_r;
      if (exp_val >= (2 ** Ne) - 1) begin
        flt.exponent = '1;
        flt.mantissa = '0;
      end else begin
        flt.exponent = exp_val[Ne-1:0];
        flt.mantissa = mant_rnd[Nm-1:0];
      end
      pack_val = zero_r ? '0 : INT_W'(flt);
    end else if (sat_r) begin
      pack_val = sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (!zero_r) begin
      pack_val = sign_r ? (~work_r + 1'b1) : work_r;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_r   <= 1'b0;
      sign_r <= 1'b0;
      zero_r <= 1'b0;
      sat_r  <= 1'b0;
      left_r <= 1'b0;
      k_r    <= '0;
      cnt_r  <= '0;
      work_r <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            sign_r <= cap_sign;
            zero_r <= cap_zero;
            sat_r  <= cap_sat;
            left_r <= cap_left;
            k_r    <= cap_k;
            cnt_r  <= cap_k;
            work_r <= cap_work;
          end
        end
        SHIFT: begin
          work_r <= left_r ? (work_r << 1) : (work_r >> 1);
          cnt_r  <= cnt_r - 6'd1;
        end
        PACK:    result <= pack_val;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/float_conv.md
FLOAT_CONV -- requirements
Module: float_conv

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge), reset_n input 1 (asynchronous, active-low).
REQ-002 SHALL have no module parameters; the float format is the shared Nm/Ne: Nf = 1+Ne+Nm, Nf ≤ 32, Ne ≥ 6.
REQ-003 SHALL have these ports:
- start  input  1: request; accepted only when busy=0.
- op  input  1: 0 = int-to-float, 1 = float-to-int.
- a  input  32: operand; signed two's-complement int, or float in a[Nf-1:0].
- busy  output  1: conversion in progress.
- done  output  1: one-cycle pulse when result becomes valid.
- result  output  32: registered result; float results are zero-extended above bit Nf-1.

Function
REQ-004 SHALL implement the FSM states IDLE, SHIFT, PACK and DONE.
REQ-005 SHALL register op and a in IDLE when start=1, then go to SHIFT with busy=1.
REQ-006 SHALL ignore start while busy=1; operands are never re-captured mid-operation.
REQ-007 SHALL shift the working register by exactly 1 bit per cycle in SHIFT while k>0, then go to PACK.
REQ-008 SHALL go from PACK to DONE, which drives done=1 for one cycle, updates result, then returns to IDLE.
REQ-009 SHALL have a latency from the start cycle to the done cycle of exactly 2+k cycles; busy=1 from the cycle after start up to and including DONE.
REQ-010 SHALL, for int-to-float, work on m=|a| (32-bit unsigned, so -2^31 gives 2^31), with k = leading zeros of m.
REQ-011 SHALL, after normalization, use exponent bias+31-k, where bias = 2^(Ne-1)-1, take the mantissa from the Nm bits below the MSB (truncated) and set the sign to a[31].
REQ-012 SHALL give result 0 and k=0 for int-to-float a=0.
REQ-013 SHALL, if the int-to-float exponent is ≥ 2^Ne-1, saturate to exponent all-ones with mantissa 0 (sign kept).
REQ-014 SHALL, for float-to-int, take e = exponent-bias and the value {1,mantissa}; k = |e-Nm|, shifting right if e<Nm and left if e>Nm.
REQ-015 SHALL truncate float-to-int toward zero and two's-complement negate the magnitude when the sign is 1.
REQ-016 SHALL give float-to-int result 0 when the exponent is 0 or e<0, with k=0.
REQ-017 SHALL, when float-to-int e ≥ 31 or the exponent is all-ones, give 0x7FFFFFFF (positive) or 0x80000000 (negative), with k=0.
REQ-018 SHALL hold result until the next DONE.

Reset
REQ-019 SHALL, on reset_n=0 at any time including mid-operation, go to IDLE with busy=0, done=0, result=0, and discard any in-flight operation.
REQ-020 SHALL accept a start in the first rising edge after reset_n deasserts.

Configuration
REQ-021 SHALL, when FLOAT_CONV_ROUND_EN is defined, round the int-to-float mantissa to nearest with ties away from zero, using the first dropped bit.
REQ-022 SHALL, on rounding overflow (mantissa all-ones + 1), set the mantissa to 0 and add 1 to the exponent, then apply the REQ-013 saturation.
REQ-023 SHALL do the rounding in PACK, adding no cycles.
REQ-024 SHALL truncate (REQ-011) when FLOAT_CONV_ROUND_EN is undefined; float-to-int is unaffected by the macro.

Structure
REQ-025 SHALL import the float typedef, Nm and Ne from float_pack.
REQ-026 SHALL put the new FSM state enum and the constants INT_W=32 and BIAS in float_pack.
REQ-027 SHALL implement leading-zero handling as the iterative SHIFT loop; one sub-module, float_conv_lzc (combinational leading-zero count computing k at capture), is permitted.

Verification (Nm=23, Ne=8)
REQ-028 SHALL check: op=0, a=1 -> result 0x3F800000, done 33 cycles after start.
REQ-029 SHALL check: op=0, a=0x80000000 -> result 0xCF000000, done 2 cycles after start.
REQ-030 SHALL check: op=0, a=0x01FFFFFF -> 0x4BFFFFFF without the macro, 0x4C000000 with FLOAT_CONV_ROUND_EN; latency 9 cycles.
REQ-031 SHALL check: op=1 with a=0x40490FDB -> 3; a=0xBFC00000 -> 0xFFFFFFFF; a=0x4F000000 -> 0x7FFFFFFF.
REQ-032 SHALL check: a second start while busy is ignored; reset_n pulsed low mid-SHIFT -> busy=0, done=0, result=0 immediately, and no done pulse follows.
